// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM line in clk_i cycles,
// reporting each complete cycle (or a stuck-line timeout) with a one-cycle valid pulse.
module pwm_capture #(
    parameter int CounterWidth = 16,
    parameter int SyncStages   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    pwm_i,
    output logic                    valid_o,
    output logic [CounterWidth-1:0] period_o,
    output logic [CounterWidth-1:0] high_o,
    output logic                    timeout_o,
    output logic                    level_o
);

    localparam logic [CounterWidth-1:0] MaxCount = '1;
    localparam logic [CounterWidth-1:0] One      = CounterWidth'(1);

    typedef enum logic {
        Idle,
        Measure
    } state_e;

    state_e                  state_q;
    logic [SyncStages-1:0]   sync_q;
    logic                    prev_q;
    logic [CounterWidth-1:0] period_cnt_q;
    logic [CounterWidth-1:0] high_cnt_q;
    logic                    sync;
    logic                    rise;

    assign sync    = sync_q[SyncStages-1];
    assign rise    = sync & ~prev_q;
    assign level_o = sync;

    // Synchroniser stage plus one extra flop for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pwm_i};
            prev_q <= sync;
        end
    end

    // Measurement stage: counters, state and registered reports
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= Idle;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            valid_o      <= 1'b0;
            period_o     <= '0;
            high_o       <= '0;
            timeout_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                Idle: begin
                    if (rise) begin
                        period_cnt_q <= One;
                        high_cnt_q   <= One;
                        state_q      <= Measure;
                    end else begin
                        period_cnt_q <= '0;
                        high_cnt_q   <= '0;
                    end
                end
                Measure: begin
                    if (rise) begin
                        period_o     <= period_cnt_q;
                        high_o       <= high_cnt_q;
                        timeout_o    <= 1'b0;
                        valid_o      <= 1'b1;
                        period_cnt_q <= One;
                        high_cnt_q   <= One;
                    end else if (period_cnt_q == MaxCount) begin
                        // No edge for a full counter range: line is stuck, level_o says which way
                        period_o     <= '0;
                        high_o       <= '0;
                        timeout_o    <= 1'b1;
                        valid_o      <= 1'b1;
                        period_cnt_q <= '0;
                        high_cnt_q   <= '0;
                        state_q      <= Idle;
                    end else begin
                        period_cnt_q <= period_cnt_q + One;
                        if (sync) begin
                            high_cnt_q <= high_cnt_q + One;
                        end
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two instances (16-bit/2-stage and 8-bit/3-stage) checked every
// cycle against a timestamp-based reference model of the measurement rules.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        pwm = 1'b0;
    logic        v16, t16, l16, v8, t8, l8;
    logic [15:0] p16, h16;
    logic [7:0]  p8, h8;

    always #5 clk = ~clk;

    pwm_capture #(.CounterWidth(16), .SyncStages(2)) dut16 (
        .clk_i(clk), .rst_ni(rst_ni), .pwm_i(pwm), .valid_o(v16),
        .period_o(p16), .high_o(h16), .timeout_o(t16), .level_o(l16)
    );

    pwm_capture #(.CounterWidth(8), .SyncStages(3)) dut8 (
        .clk_i(clk), .rst_ni(rst_ni), .pwm_i(pwm), .valid_o(v8),
        .period_o(p8), .high_o(h8), .timeout_o(t8), .level_o(l8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: line history indexed by clock edge since reset release
    bit hist [0:16383];
    int e;
    int ss   [2] = '{2, 3};
    int maxc [2] = '{65535, 255};
    bit armed[2];
    int rpos [2];
    int ev   [2];
    int ep   [2];
    int eh   [2];
    int et   [2];
    int vcnt8;
    int tcnt8;

    function automatic bit pv(int k);
        return (k >= 1 && k <= e) ? hist[k] : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic model_reset();
        e = 0;
        for (int w = 0; w < 2; w++) begin
            armed[w] = 1'b0;
            rpos[w]  = 0;
            ev[w]    = 0;
            ep[w]    = 0;
            eh[w]    = 0;
            et[w]    = 0;
        end
    endtask

    task automatic model_edge();
        int j;
        int hs;
        bit r;
        if (e >= 16383) begin
            $display("FAIL model_range: edge index %0d exceeds history 16383", e);
            $fatal(1, "history overflow");
        end
        e++;
        hist[e] = pwm;
        for (int w = 0; w < 2; w++) begin
            j = e - ss[w];
            r = pv(j) && !pv(j - 1);
            ev[w] = 0;
            if (armed[w]) begin
                if (r) begin
                    hs = 0;
                    for (int k = rpos[w]; k < j; k++) hs += int'(pv(k));
                    ev[w] = 1; ep[w] = j - rpos[w]; eh[w] = hs; et[w] = 0;
                    rpos[w] = j;
                end else if (j - rpos[w] == maxc[w]) begin
                    ev[w] = 1; ep[w] = 0; eh[w] = 0; et[w] = 1;
                    armed[w] = 1'b0;
                end
            end else if (r) begin
                armed[w] = 1'b1;
                rpos[w]  = j;
            end
        end
    endtask

    task automatic check_all();
        chk("valid16",   32'(v16), 32'(ev[0]));
        chk("period16",  32'(p16), 32'(ep[0]));
        chk("high16",    32'(h16), 32'(eh[0]));
        chk("timeout16", 32'(t16), 32'(et[0]));
        chk("level16",   32'(l16), 32'(pv(e - ss[0] + 1)));
        chk("valid8",    32'(v8),  32'(ev[1]));
        chk("period8",   32'(p8),  32'(ep[1]));
        chk("high8",     32'(h8),  32'(eh[1]));
        chk("timeout8",  32'(t8),  32'(et[1]));
        chk("level8",    32'(l8),  32'(pv(e - ss[1] + 1)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_v16"}, 32'(v16), 32'd0);
        chk({tag, "_p16"}, 32'(p16), 32'd0);
        chk({tag, "_h16"}, 32'(h16), 32'd0);
        chk({tag, "_t16"}, 32'(t16), 32'd0);
        chk({tag, "_l16"}, 32'(l16), 32'd0);
        chk({tag, "_v8"},  32'(v8),  32'd0);
        chk({tag, "_p8"},  32'(p8),  32'd0);
        chk({tag, "_h8"},  32'(h8),  32'd0);
        chk({tag, "_t8"},  32'(t8),  32'd0);
        chk({tag, "_l8"},  32'(l8),  32'd0);
    endtask

    task automatic tick(input bit v);
        pwm = v;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (v8 === 1'b1) vcnt8++;
        if (v8 === 1'b1 && t8 === 1'b1) tcnt8++;
    endtask

    task automatic pwm_periods(input int period, input int high, input int n);
        for (int i = 0; i < n; i++)
            for (int c = 0; c < period; c++) tick(c < high);
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    initial begin
        int per;
        int hi;

        // Power-on reset
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        rst_ni = 1'b1;

        // Steady 100/25 with a random leading idle
        hold(1'b0, $urandom_range(1, 20));
        pwm_periods(100, 25, 5);

        // Mid-run reset while the input keeps toggling
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        check_zero("rst_async");
        for (int i = 0; i < 5; i++) begin
            pwm = ~pwm;
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        rst_ni = 1'b1;
        pwm    = 1'b0;
        model_reset();
        pwm_periods(10, 4, 1);

        // Randomised PWM shapes
        for (int i = 0; i < 6; i++) begin
            per = $urandom_range(2, 60);
            hi  = $urandom_range(1, per - 1);
            pwm_periods(per, hi, 3);
        end
        for (int i = 0; i < 200; i++) tick(1'($urandom_range(0, 1)));

        // Minimum period, then a line that is mostly high
        pwm_periods(2, 1, 10);
        pwm_periods(4, 3, 5);

        // Stuck low after period-10 cycles
        pwm_periods(10, 5, 3);
        vcnt8 = 0;
        tcnt8 = 0;
        hold(1'b0, 300);
        chk("stuck_low_pulses8",   32'(vcnt8), 32'd1);
        chk("stuck_low_timeouts8", 32'(tcnt8), 32'd1);

        // Stuck high, then recovery with 50/20
        vcnt8 = 0;
        tcnt8 = 0;
        hold(1'b1, 300);
        chk("stuck_high_pulses8",   32'(vcnt8), 32'd1);
        chk("stuck_high_timeouts8", 32'(tcnt8), 32'd1);
        hold(1'b0, 10);
        pwm_periods(50, 20, 4);

        // Counter boundary: 255 is measurable, 256 times out
        tcnt8 = 0;
        pwm_periods(255, 100, 3);
        chk("period255_no_timeout8", 32'(tcnt8), 32'd0);
        pwm_periods(256, 100, 3);
        hold(1'b0, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
